// File: rtl/stack_controller.sv
// Stack pointer owner and sequencer for the CPU stack memory: push/pop/peek/set-esp
// over a req/ack handshake, with overflow/underflow/alignment rejection.
module stack_controller #(
  parameter logic [31:0] STACK_TOP  = 32'd256,
  parameter logic [31:0] STACK_BASE = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [31:0] wdata,
  input  logic [7:0]  offset,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] esp,
  output logic        empty,
  output logic        full,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE, ERR} state_t;
  localparam logic [1:0] OP_PUSH = 2'd0, OP_POP = 2'd1, OP_PEEK = 2'd2, OP_SET = 2'd3;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [31:0] wdata_q;
  logic [7:0]  offset_q;
  logic [31:0] esp_nxt;
  logic        reject;
  logic [31:0] peek_end;
  logic [32:0] base_diff;

  assign peek_end  = esp + {24'd0, offset} + 32'd4;
  // Borrow out of the subtraction flags wdata below the base without a constant compare.
  assign base_diff = {1'b0, wdata} - {1'b0, STACK_BASE};

  always_comb begin
    reject = 1'b0;
    case (op)
      OP_PUSH: reject = full;
      OP_POP:  reject = empty;
      OP_PEEK: reject = (peek_end > STACK_TOP) || (offset[1:0] != 2'd0);
      OP_SET:  reject = (wdata[1:0] != 2'd0) || (wdata > STACK_TOP) || base_diff[32];
      default: reject = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = reject ? ERR : EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    esp_nxt = esp;
    if (state == EXEC) begin
      case (op_q)
        OP_PUSH: esp_nxt = esp - 32'd4;
        OP_POP:  esp_nxt = esp + 32'd4;
        OP_SET:  esp_nxt = wdata_q;
        default: esp_nxt = esp;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = esp;
    mem_wdata = 32'd0;
    if (state == EXEC) begin
      case (op_q)
        OP_PUSH: begin
          mem_we    = 1'b1;
          mem_addr  = esp - 32'd4;
          mem_wdata = wdata_q;
        end
        OP_PEEK: mem_addr = esp + {24'd0, offset_q};
        default: mem_addr = esp;
      endcase
    end
  end

  assign ack = (state == DONE) || (state == ERR);
  assign err = (state == ERR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      esp      <= STACK_TOP;
      empty    <= 1'b1;
      full     <= (STACK_TOP == STACK_BASE);
      rdata    <= 32'd0;
      op_q     <= 2'd0;
      wdata_q  <= 32'd0;
      offset_q <= 8'd0;
    end else begin
      state <= state_nxt;
      esp   <= esp_nxt;
      empty <= (esp_nxt == STACK_TOP);
      full  <= (esp_nxt == STACK_BASE);
      if (state == IDLE && req) begin
        op_q     <= op;
        wdata_q  <= wdata;
        offset_q <= offset;
      end
      if (state == EXEC && (op_q == OP_POP || op_q == OP_PEEK))
        rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller: drivers queue expected acks and memory writes,
// monitors compare them as the DUT presents them.
module tb_stack_controller;

  logic        clock = 1'b0;
  logic        reset, req;
  logic [1:0]  op;
  logic [31:0] wdata;
  logic [7:0]  offset;
  logic        ack, err, empty, full, mem_we;
  logic [31:0] rdata, esp, mem_addr, mem_wdata, mem_rdata;

  stack_controller dut (
    .clock(clock), .reset(reset), .req(req), .op(op), .wdata(wdata), .offset(offset),
    .ack(ack), .err(err), .rdata(rdata), .esp(esp), .empty(empty), .full(full),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [0:63];
  assign mem_rdata = (mem_addr < 32'd256) ? mem[mem_addr[7:2]] : 32'd0;
  always @(posedge clock) if (mem_we && mem_addr < 32'd256) mem[mem_addr[7:2]] <= mem_wdata;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] esp;
    logic        empty;
    logic        full;
    int          cyc;
  } ack_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_exp_t;

  ack_exp_t ack_q[$];
  wr_exp_t  wr_q[$];
  int cyc = 0, compared = 0, mismatched = 0, ack_cnt = 0;
  bit wr_mon_en = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ack monitor
  initial forever begin
    @(negedge clock);
    if (!reset && ack) begin
      ack_exp_t e;
      ack_cnt++;
      if (ack_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
      else begin
        e = ack_q.pop_front();
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        chk("err", {31'd0, err}, {31'd0, e.err});
        chk("rdata", rdata, e.rdata);
        chk("esp", esp, e.esp);
        chk("empty", {31'd0, empty}, {31'd0, e.empty});
        chk("full", {31'd0, full}, {31'd0, e.full});
      end
    end
  end

  // Memory write monitor
  initial forever begin
    @(negedge clock);
    if (wr_mon_en && mem_we) begin
      wr_exp_t w;
      if (wr_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        w = wr_q.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(w.cyc));
        chk("wr_addr", mem_addr, w.addr);
        chk("wr_data", mem_wdata, w.data);
      end
    end
  end

  // Issue one request; expected results are hand-computed by the caller.
  task automatic do_op(input logic [1:0] o, input logic [31:0] d, input logic [7:0] off,
                       input logic e_err, input logic [31:0] e_rdata, input logic [31:0] e_esp,
                       input logic e_empty, input logic e_full);
    ack_exp_t e;
    wr_exp_t  w;
    bit got;
    @(posedge clock); #1;
    req = 1'b1; op = o; wdata = d; offset = off;
    e.err = e_err; e.rdata = e_rdata; e.esp = e_esp; e.empty = e_empty; e.full = e_full;
    e.cyc = cyc + (e_err ? 1 : 2);
    ack_q.push_back(e);
    if (o == 2'd0 && !e_err) begin
      w.addr = e_esp; w.data = d; w.cyc = cyc + 1;
      wr_q.push_back(w);
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      if (ack) got = 1'b1;
    end
    if (!got) begin
      compared++; mismatched++;
      $display("FAIL ack_timeout: got no ack expected ack within 10 cycles (op %0d)", o);
      void'(ack_q.pop_back());
    end
    @(posedge clock); #1;
    req = 1'b0;
  endtask

  initial begin
    int a0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    reset = 1'b1; req = 1'b0; op = 2'd0; wdata = 32'd0; offset = 8'd0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_esp", esp, 32'd256);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ack", {30'd0, ack, err}, 32'd0);
    chk("rst_mem", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd256);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);

    //     op    wdata          off  err rdata          esp   empty full
    do_op(2'd0, 32'h11223344, 8'd0, 0, 32'h0,        32'd252, 0, 0);
    do_op(2'd0, 32'hA,        8'd0, 0, 32'h0,        32'd248, 0, 0);
    do_op(2'd0, 32'hB,        8'd0, 0, 32'h0,        32'd244, 0, 0);
    do_op(2'd1, 32'h0,        8'd0, 0, 32'hB,        32'd248, 0, 0);
    do_op(2'd1, 32'h0,        8'd0, 0, 32'hA,        32'd252, 0, 0);
    do_op(2'd1, 32'h0,        8'd0, 0, 32'h11223344, 32'd256, 1, 0);
    do_op(2'd1, 32'h0,        8'd0, 1, 32'h11223344, 32'd256, 1, 0);
    do_op(2'd3, 32'd4,        8'd0, 0, 32'h11223344, 32'd4,   0, 0);
    do_op(2'd0, 32'h55,       8'd0, 0, 32'h11223344, 32'd0,   0, 1);
    do_op(2'd0, 32'h66,       8'd0, 1, 32'h11223344, 32'd0,   0, 1);
    do_op(2'd3, 32'h102,      8'd0, 1, 32'h11223344, 32'd0,   0, 1);
    do_op(2'd3, 32'd260,      8'd0, 1, 32'h11223344, 32'd0,   0, 1);
    do_op(2'd3, 32'd256,      8'd0, 0, 32'h11223344, 32'd256, 1, 0);
    do_op(2'd0, 32'd1,        8'd0, 0, 32'h11223344, 32'd252, 0, 0);
    do_op(2'd0, 32'd2,        8'd0, 0, 32'h11223344, 32'd248, 0, 0);
    do_op(2'd0, 32'd3,        8'd0, 0, 32'h11223344, 32'd244, 0, 0);
    do_op(2'd2, 32'd0,        8'd8, 0, 32'd1,        32'd244, 0, 0);
    do_op(2'd2, 32'd0,        8'd2, 1, 32'd1,        32'd244, 0, 0);
    do_op(2'd2, 32'd0,        8'd12,1, 32'd1,        32'd244, 0, 0);
    do_op(2'd2, 32'd0,        8'd0, 0, 32'd3,        32'd244, 0, 0);

    // Reset landing on the EXEC cycle of a PUSH: no ack, esp restored.
    wr_mon_en = 1'b0;
    a0 = ack_cnt;
    @(posedge clock); #1;
    req = 1'b1; op = 2'd0; wdata = 32'h77;
    @(posedge clock); #1;
    req = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("rst_exec_ack_count", 32'(ack_cnt - a0), 32'd0);
    chk("rst_exec_esp", esp, 32'd256);
    chk("rst_exec_empty", {31'd0, empty}, 32'd1);
    chk("rst_exec_full", {31'd0, full}, 32'd0);
    wr_mon_en = 1'b1;
    do_op(2'd0, 32'h99, 8'd0, 0, 32'd0, 32'd252, 0, 0);

    repeat (3) @(negedge clock);
    chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

endmodule
